// File: rtl/cart_sram_arbiter.sv
// rtl/cart_sram_arbiter.sv - byte-wide arbiter/sequencer for the shared 16-bit cartridge SRAM
module cart_sram_arbiter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock4,
   input  logic        reset,
   input  logic        prog,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [17:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic        ldr_req,
   input  logic [17:0] ldr_addr,
   input  logic [7:0]  ldr_wdata,
   output logic        ldr_ack,
   output logic        busy,
   output logic [17:0] SRAM_A,
   inout  wire  [15:0] SRAM_D,
   output logic        SRAM_CE_n,
   output logic        SRAM_OE_n,
   output logic        SRAM_WE_n,
   output logic        SRAM_UB_n,
   output logic        SRAM_LB_n
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // ACCESS lasts WAIT_CYCLES cycles: load WAIT_CYCLES-1 and leave when the counter reads zero
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  wait_cnt;
   logic        lat_ldr;
   logic        lat_we;
   logic [17:0] lat_addr;
   logic [7:0]  lat_wdata;
   logic        grant_cpu;
   logic        grant_ldr;
   logic        drive_d;
   logic        access_last;

   assign access_last = (state == ST_ACCESS) && (wait_cnt == 4'd0);

   // State register; reset drops any transaction in flight without an ack
   always_ff @(posedge clock4) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, grant decision and SRAM strobes decoded from the current state
   always_comb begin
      state_nxt = state;
      grant_cpu = 1'b0;
      grant_ldr = 1'b0;
      busy      = 1'b1;
      cpu_ack   = 1'b0;
      ldr_ack   = 1'b0;
      drive_d   = 1'b0;
      SRAM_CE_n = 1'b1;
      SRAM_OE_n = 1'b1;
      SRAM_WE_n = 1'b1;
      SRAM_UB_n = 1'b1;
      SRAM_LB_n = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (prog) begin
               if (ldr_req) begin
                  grant_ldr = 1'b1;
                  state_nxt = ST_SETUP;
               end
            end else if (cpu_req) begin
               grant_cpu = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            SRAM_CE_n = 1'b0;
            SRAM_UB_n = ~lat_addr[0];
            SRAM_LB_n = lat_addr[0];
            drive_d   = lat_we;
            state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            SRAM_CE_n = 1'b0;
            SRAM_UB_n = ~lat_addr[0];
            SRAM_LB_n = lat_addr[0];
            SRAM_OE_n = lat_we;
            SRAM_WE_n = ~lat_we;
            drive_d   = lat_we;
            if (wait_cnt == 4'd0) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            SRAM_CE_n = 1'b0;
            SRAM_UB_n = ~lat_addr[0];
            SRAM_LB_n = lat_addr[0];
            drive_d   = lat_we;
            cpu_ack   = ~lat_ldr;
            ldr_ack   = lat_ldr;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latch the granted request so later changes on the request inputs cannot disturb it
   always_ff @(posedge clock4) begin
      if (reset) begin
         lat_ldr   <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= 18'd0;
         lat_wdata <= 8'd0;
      end else if (grant_ldr) begin
         lat_ldr   <= 1'b1;
         lat_we    <= 1'b1;
         lat_addr  <= ldr_addr;
         lat_wdata <= ldr_wdata;
      end else if (grant_cpu) begin
         lat_ldr   <= 1'b0;
         lat_we    <= cpu_we;
         lat_addr  <= cpu_addr;
         lat_wdata <= cpu_wdata;
      end
   end

   // Strobe-width down-counter, loaded on the way into ACCESS
   always_ff @(posedge clock4) begin
      if (reset) begin
         wait_cnt <= 4'd0;
      end else if (state == ST_SETUP) begin
         wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_ACCESS) && (wait_cnt != 4'd0)) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Capture the selected byte lane at the edge leaving ACCESS of a CPU read
   always_ff @(posedge clock4) begin
      if (reset) begin
         cpu_rdata <= 8'd0;
      end else if (access_last && !lat_we && !lat_ldr) begin
         cpu_rdata <= lat_addr[0] ? SRAM_D[15:8] : SRAM_D[7:0];
      end
   end

   assign SRAM_A = {1'b0, lat_addr[17:1]};
   assign SRAM_D = drive_d ? {lat_wdata, lat_wdata} : 16'hzzzz;

endmodule

// File: tb/tb_cart_sram_arbiter.sv
// tb/tb_cart_sram_arbiter.sv - self-checking bench for cart_sram_arbiter
module tb_cart_sram_arbiter;

   localparam int W = 2;

   logic        clock4 = 1'b0;
   logic        reset = 1'b1;
   logic        prog = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [17:0] cpu_addr = 18'd0;
   logic [7:0]  cpu_wdata = 8'd0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        ldr_req = 1'b0;
   logic [17:0] ldr_addr = 18'd0;
   logic [7:0]  ldr_wdata = 8'd0;
   logic        ldr_ack;
   logic        busy;
   logic [17:0] SRAM_A;
   wire  [15:0] SRAM_D;
   logic        SRAM_CE_n;
   logic        SRAM_OE_n;
   logic        SRAM_WE_n;
   logic        SRAM_UB_n;
   logic        SRAM_LB_n;

   cart_sram_arbiter #(.WAIT_CYCLES(W)) dut (
      .clock4(clock4), .reset(reset), .prog(prog),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
      .busy(busy), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
      .SRAM_CE_n(SRAM_CE_n), .SRAM_OE_n(SRAM_OE_n), .SRAM_WE_n(SRAM_WE_n),
      .SRAM_UB_n(SRAM_UB_n), .SRAM_LB_n(SRAM_LB_n)
   );

   always #5 clock4 = ~clock4;

   // Asynchronous SRAM model plus a bench probe driver for the idle-bus check
   logic [15:0] sram [0:131071];
   logic        tb_probe = 1'b0;
   assign SRAM_D = (!SRAM_CE_n && !SRAM_OE_n && SRAM_WE_n) ? sram[SRAM_A[16:0]] : 16'hzzzz;
   assign SRAM_D = tb_probe ? 16'h0000 : 16'hzzzz;

   always @(posedge clock4) begin
      if (!SRAM_CE_n && !SRAM_WE_n) begin
         if (!SRAM_LB_n) sram[SRAM_A[16:0]][7:0]  <= SRAM_D[7:0];
         if (!SRAM_UB_n) sram[SRAM_A[16:0]][15:8] <= SRAM_D[15:8];
      end
   end

   // Ack pulse counters
   int n_cpu_ack = 0;
   int n_ldr_ack = 0;
   always @(posedge clock4) begin
      if (cpu_ack) n_cpu_ack <= n_cpu_ack + 1;
      if (ldr_ack) n_ldr_ack <= n_ldr_ack + 1;
   end

   // Reference model: byte-addressed store with a written flag
   logic [7:0] ref_mem [0:262143];
   bit         ref_vld [0:262143];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock4);
      @(negedge clock4);
   endtask

   // One complete transaction from an idle arbiter, checking strobes and timing
   task automatic xact(input bit ldr, input bit we, input logic [17:0] addr,
                       input logic [7:0] wd, output logic [7:0] rd);
      int k;
      int oe_c;
      int we_c;
      int other0;
      bit got;
      bit ce_ok;
      logic [17:0] ca;
      logic [1:0]  lanes;
      logic [15:0] cd;
      k = 0; oe_c = 0; we_c = 0; got = 0; ce_ok = 1;
      ca = '0; lanes = 2'b11; cd = '0;
      other0 = ldr ? n_cpu_ack : n_ldr_ack;
      prog = ldr;
      if (ldr) begin
         ldr_req = 1'b1; ldr_addr = addr; ldr_wdata = wd;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      end
      while (!got && k < 40) begin
         step();
         k++;
         if (!SRAM_OE_n) oe_c++;
         if (!SRAM_WE_n) we_c++;
         if (!SRAM_OE_n || !SRAM_WE_n) begin
            ca = SRAM_A;
            lanes = {SRAM_UB_n, SRAM_LB_n};
            cd = SRAM_D;
            if (SRAM_CE_n) ce_ok = 0;
         end
         got = ldr ? ldr_ack : cpu_ack;
      end
      rd = cpu_rdata;
      ldr_req = 1'b0;
      cpu_req = 1'b0;
      check("ack_seen", got, 1);
      check("ack_latency", k, W + 2);
      check("oe_low_cycles", oe_c, we ? 0 : W);
      check("we_low_cycles", we_c, we ? W : 0);
      check("ce_during_strobe", ce_ok, 1);
      check("sram_word_addr", ca, {1'b0, addr[17:1]});
      check("byte_lane", lanes, addr[0] ? 2'b01 : 2'b10);
      if (we) check("write_bus", cd, {wd, wd});
      check("no_foreign_ack", (ldr ? n_cpu_ack : n_ldr_ack) - other0, 0);
      step();
      check("idle_after", busy, 0);
   endtask

   task automatic run(input bit ldr, input bit we, input logic [17:0] addr,
                      input logic [7:0] wd, output logic [7:0] rd);
      xact(ldr, we, addr, wd, rd);
      if (we) begin
         ref_mem[addr] = wd;
         ref_vld[addr] = 1'b1;
      end else if (ref_vld[addr]) begin
         check("read_data", rd, ref_mem[addr]);
      end
   endtask

   typedef struct {
      bit          ldr;
      bit          we;
      logic [17:0] addr;
      logic [7:0]  wd;
      bit          chk;
      logic [7:0]  exp;
   } vec_t;

   vec_t vt [14];

   initial begin
      logic [7:0] rd;
      int k;
      int c0;
      int l0;
      int bad;
      bit got;

      for (int i = 0; i < 262144; i++) ref_vld[i] = 1'b0;
      for (int i = 0; i < 131072; i++) sram[i] = 16'h0000;
      sram[0] = 16'hA55A;
      ref_mem[0] = 8'h5A; ref_vld[0] = 1'b1;
      ref_mem[1] = 8'hA5; ref_vld[1] = 1'b1;

      vt[0]  = '{0, 0, 18'h00001, 8'h00, 1, 8'hA5};
      vt[1]  = '{0, 0, 18'h00000, 8'h00, 1, 8'h5A};
      vt[2]  = '{1, 1, 18'h00100, 8'h3C, 0, 8'h00};
      vt[3]  = '{0, 0, 18'h00100, 8'h00, 1, 8'h3C};
      vt[4]  = '{0, 1, 18'h00101, 8'hC3, 0, 8'h00};
      vt[5]  = '{0, 0, 18'h00101, 8'h00, 1, 8'hC3};
      vt[6]  = '{0, 0, 18'h00100, 8'h00, 1, 8'h3C};
      vt[7]  = '{1, 1, 18'h3FFFF, 8'h7E, 0, 8'h00};
      vt[8]  = '{1, 1, 18'h3FFFE, 8'h81, 0, 8'h00};
      vt[9]  = '{0, 0, 18'h3FFFF, 8'h00, 1, 8'h7E};
      vt[10] = '{0, 0, 18'h3FFFE, 8'h00, 1, 8'h81};
      vt[11] = '{0, 1, 18'h00000, 8'hEE, 0, 8'h00};
      vt[12] = '{0, 0, 18'h00001, 8'h00, 1, 8'hA5};
      vt[13] = '{0, 0, 18'h00000, 8'h00, 1, 8'hEE};

      // Reset and idle
      repeat (3) @(posedge clock4);
      @(negedge clock4);
      reset = 1'b0;
      repeat (10) step();
      check("rst_strobes", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n, SRAM_LB_n}, 5'h1F);
      check("rst_busy", busy, 0);
      check("rst_acks", {cpu_ack, ldr_ack}, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_addr", SRAM_A, 0);

      // Table vectors
      for (int i = 0; i < 14; i++) begin
         run(vt[i].ldr, vt[i].we, vt[i].addr, vt[i].wd, rd);
         if (vt[i].chk) check("vec_rdata", rd, vt[i].exp);
      end

      // Bus must be released when idle, even right after a write
      run(0, 1, 18'h00050, 8'hFF, rd);
      tb_probe = 1'b1;
      #1;
      check("sram_d_idle_released", SRAM_D, 16'h0000);
      tb_probe = 1'b0;

      // Both requesting under prog: loader wins, CPU stalls until prog drops
      c0 = n_cpu_ack; l0 = n_ldr_ack;
      prog = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00100; cpu_wdata = 8'h00;
      ldr_req = 1'b1; ldr_addr = 18'h00200; ldr_wdata = 8'h55;
      k = 0; got = 0;
      while (!got && k < 40) begin step(); k++; got = ldr_ack; end
      check("both_ldr_ack", got, 1);
      ldr_req = 1'b0;
      ref_mem[18'h00200] = 8'h55; ref_vld[18'h00200] = 1'b1;
      repeat (6) step();
      check("cpu_stalled", n_cpu_ack - c0, 0);
      check("ldr_single_ack", n_ldr_ack - l0, 1);
      prog = 1'b0;
      k = 0; got = 0;
      while (!got && k < 40) begin step(); k++; got = cpu_ack; end
      check("cpu_after_prog_ack", got, 1);
      check("cpu_after_prog_within", k <= W + 3, 1);
      check("cpu_after_prog_rdata", cpu_rdata, 8'h3C);
      cpu_req = 1'b0;
      step();

      // Reset pulsed during ACCESS of a write
      l0 = n_ldr_ack;
      prog = 1'b1; ldr_req = 1'b1; ldr_addr = 18'h30000; ldr_wdata = 8'hAB;
      step();
      step();
      check("rst_mid_we_low", SRAM_WE_n, 0);
      reset = 1'b1;
      step();
      check("rst_mid_we_high", SRAM_WE_n, 1);
      check("rst_mid_ce_high", SRAM_CE_n, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_addr", SRAM_A, 0);
      reset = 1'b0; ldr_req = 1'b0;
      step();
      check("rst_mid_no_ack", n_ldr_ack - l0, 0);
      run(1, 1, 18'h30000, 8'hCD, rd);
      run(0, 0, 18'h30000, 8'h00, rd);

      // Request dropped before the ack still completes
      l0 = n_ldr_ack;
      prog = 1'b1; ldr_req = 1'b1; ldr_addr = 18'h00300; ldr_wdata = 8'h99;
      step();
      ldr_req = 1'b0;
      k = 1; got = 0;
      while (!got && k < 40) begin step(); k++; got = ldr_ack; end
      check("drop_ack", got, 1);
      check("drop_latency", k, W + 2);
      ref_mem[18'h00300] = 8'h99; ref_vld[18'h00300] = 1'b1;
      step();
      check("drop_ack_count", n_ldr_ack - l0, 1);
      run(0, 0, 18'h00300, 8'h00, rd);

      // prog raised mid-transaction: ack still goes to the CPU
      l0 = n_ldr_ack; c0 = n_cpu_ack;
      prog = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00301; cpu_wdata = 8'h66;
      step();
      prog = 1'b1;
      k = 1; got = 0;
      while (!got && k < 40) begin step(); k++; got = cpu_ack; end
      check("toggle_cpu_ack", got, 1);
      cpu_req = 1'b0;
      ref_mem[18'h00301] = 8'h66; ref_vld[18'h00301] = 1'b1;
      step();
      check("toggle_no_ldr_ack", n_ldr_ack - l0, 0);
      check("toggle_one_cpu_ack", n_cpu_ack - c0, 1);
      run(0, 0, 18'h00301, 8'h00, rd);

      // 256 back-to-back loader writes with ldr_req held high throughout
      l0 = n_ldr_ack; bad = 0;
      prog = 1'b1; ldr_req = 1'b1; ldr_addr = 18'h20000; ldr_wdata = 8'h5A;
      for (int i = 0; i < 256; i++) begin
         k = 0; got = 0;
         while (!got && k < 40) begin step(); k++; got = ldr_ack; end
         if (!got || k != ((i == 0) ? W + 2 : W + 3)) bad++;
         ref_mem[18'h20000 + i] = 8'(i) ^ 8'h5A;
         ref_vld[18'h20000 + i] = 1'b1;
         if (i < 255) begin
            ldr_addr = 18'h20000 + 18'(i + 1);
            ldr_wdata = 8'(i + 1) ^ 8'h5A;
         end else begin
            ldr_req = 1'b0;
         end
      end
      step();
      check("b2b_spacing_errors", bad, 0);
      check("b2b_ack_count", n_ldr_ack - l0, 256);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         xact(0, 0, 18'h20000 + 18'(i), 8'h00, rd);
         if (rd !== (8'(i) ^ 8'h5A)) bad++;
      end
      check("b2b_readback_errors", bad, 0);

      // Randomised traffic against the byte-store reference
      for (int n = 0; n < 150; n++) begin
         bit r_ldr;
         bit r_we;
         r_ldr = ($urandom % 3) == 0;
         r_we = r_ldr ? 1'b1 : 1'($urandom % 2);
         run(r_ldr, r_we, 18'h01000 + 18'($urandom_range(0, 31)), 8'($urandom), rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
